cr_biu_arb: RTL and testbench
=============================

# cr_biu_arb

Two-requester arbiter and sequencer in front of the AHB-Lite master interface (`cr_ahbl_if`). It shares the single CPU-side request port between instruction fetch (IFU) and load/store (LSU). It locks the selected requester's address phase until the bus grants it, and tracks which requester owns the outstanding data phase. Completion, data-valid, read data and access error are routed only to that owner.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, read/write data width

Ports:
- ahbl_gated_clk  in  1  BIU clock; all state on rising edge
- cpurst  in  1  synchronous, active-high reset
- ifu_biu_req  in  1  IFU fetch request; held until granted
- ifu_biu_addr  in  ADDR_WIDTH  IFU address; fetch is always word-size, read
- ifu_biu_prot  in  4  IFU HPROT
- lsu_biu_req  in  1  LSU request; held until granted
- lsu_biu_addr  in  ADDR_WIDTH  LSU address
- lsu_biu_write  in  1  LSU write
- lsu_biu_size  in  2  LSU size
- lsu_biu_prot  in  4  LSU HPROT
- lsu_biu_wdata  in  DATA_WIDTH  LSU write data; held until lsu_biu_trans_cmplt
- cpu_req_grnt, cpu_trans_cmplt, cpu_data_vld, cpu_acc_err  in  1 each  from AHB-Lite master
- cpu_rdata  in  DATA_WIDTH  from AHB-Lite master
- cpu_req, cpu_write  out  1 each  to AHB-Lite master
- cpu_addr  out  ADDR_WIDTH  to AHB-Lite master
- cpu_size  out  2  to AHB-Lite master
- cpu_prot  out  4  to AHB-Lite master
- cpu_wr_data  out  DATA_WIDTH  to AHB-Lite master
- ifu_biu_grnt, ifu_biu_trans_cmplt, ifu_biu_data_vld, ifu_biu_acc_err  out  1 each
- lsu_biu_grnt, lsu_biu_trans_cmplt, lsu_biu_data_vld, lsu_biu_acc_err  out  1 each
- biu_rdata  out  DATA_WIDTH  shared read data, qualified by the *_data_vld outputs
- biu_arb_idle  out  1  no lock and no outstanding data phase

## Operation
- **Address-phase select (addr_sel).**
  - When no lock is held, addr_sel comes from a combinational pick among the current requests.
  - When a lock is held, addr_sel is the locked requester.
- **cpu_req.** cpu_req = selected requester's req. cpu_addr, cpu_write, cpu_size and cpu_prot are muxed by addr_sel.
  - IFU selected: cpu_write=0, cpu_size=2'b10.
- **Lock.**
  - Set when cpu_req=1 and cpu_req_grnt=0; lock_sel <= addr_sel.
  - Cleared on the cycle cpu_req_grnt=1.
  - While locked, the other requester is never presented. The address is therefore stable across hready-low wait states (AHB rule).
- **Grant routing.** The requester that equals addr_sel gets `<req>_grnt = cpu_req_grnt & cpu_req`. The other requester's grant is 0.
- **Data-phase tracking.**
  - On a grant: dp_vld <= 1, dp_sel <= addr_sel.
  - Else, on cpu_trans_cmplt: dp_vld <= 0.
  - Grant and complete in the same cycle (back-to-back): dp_sel takes the new owner and dp_vld stays 1.
- **Response routing.** cpu_trans_cmplt, cpu_data_vld and cpu_acc_err go only to the dp_sel requester, and only when dp_vld=1. With dp_vld=0 they are dropped.
- **Data paths.**
  - biu_rdata = cpu_rdata.
  - cpu_wr_data = lsu_biu_wdata. Only the LSU writes.
- **Error.** Master ERROR1/ERROR2 issue no grants. The acc_err and trans_cmplt pulse in ERROR2 go to dp_sel, then dp_vld clears.
- **Reset.** While cpurst=1, lock, dp_vld, dp_sel and last_grnt clear (last_grnt=IFU). Any outstanding transfer is abandoned.
- **Reset values.** All 1-bit outputs are 0 except biu_arb_idle=1. With no request present, cpu_addr, cpu_write, cpu_size and cpu_prot follow the IFU inputs (addr_sel defaults to IFU).

## Timing
- Request to cpu_req: 0 cycles, combinational.
- Grant to the requester: same cycle as cpu_req_grnt.
- Completion and data: same cycle as the master's cpu_trans_cmplt / cpu_data_vld. Minimum request-to-data is 1 cycle.
- Lock takes effect from the cycle after the first ungranted cpu_req.
- At most one outstanding data phase, plus one address phase granted in the same cycle the data phase completes.

## Configuration
- **BIU_ARB_RR_EN defined.** Round-robin. A register last_grnt updates on every grant. With both requests present and no lock, the requester not equal to last_grnt wins.
- **BIU_ARB_RR_EN undefined.** Fixed priority: LSU wins over IFU. The last_grnt register is not built.

## Structure
- Shared package / constants file holds:
  - requester IDs: BIU_SEL_IFU=1'b0, BIU_SEL_LSU=1'b1
  - IFU fixed size constant 2'b10
- One sub-module, `cr_biu_arb_pick`. It is the combinational picker: inputs are the two reqs, lock, lock_sel and last_grnt; output is addr_sel. The macro is confined to it plus the last_grnt register.

## Test plan
- IFU alone, addr 0x0000_1000, grant cycle 1, cmplt/data_vld cycle 2 -> ifu_biu_grnt@1, ifu_biu_data_vld@2, biu_rdata=0x1234_5678; all lsu_* outputs stay 0.
- IFU and LSU both requesting (LSU write 0x2000_0004, data 0xDEAD_BEEF), fixed priority -> LSU granted first with cpu_write=1 and cpu_wr_data=0xDEAD_BEEF; IFU granted on the LSU completion cycle (back-to-back) and dp_sel switches to IFU.
- LSU request with cpu_req_grnt held 0 for 3 cycles while IFU raises its request -> cpu_addr stays at the LSU address all 3 cycles and IFU receives no grant.
- Error response on an LSU read -> lsu_biu_acc_err and lsu_biu_trans_cmplt pulse together in ERROR2, lsu_biu_data_vld never asserts, and biu_arb_idle=1 the next cycle.
- BIU_ARB_RR_EN defined, both requesters continuously active, 6 grants -> order IFU... alternates as LSU, IFU, LSU, IFU, LSU, IFU (last_grnt resets to IFU).
- cpurst pulsed during an outstanding IFU data phase -> the master's later cpu_trans_cmplt is dropped, and biu_arb_idle=1 from the cycle after reset.

Source files
------------

// File: rtl/cr_biu_arb_pkg.sv
// Shared requester IDs and constants for the BIU request arbiter.
package cr_biu_arb_pkg;

  typedef enum logic {
    BIU_SEL_IFU = 1'b0,
    BIU_SEL_LSU = 1'b1
  } biu_sel_e;

  localparam logic [1:0] BIU_IFU_SIZE = 2'b10;

  function automatic biu_sel_e biu_other_sel(input biu_sel_e sel);
    return (sel == BIU_SEL_IFU) ? BIU_SEL_LSU : BIU_SEL_IFU;
  endfunction

endpackage

// File: rtl/cr_biu_arb_if.sv
// Requester and AHB-Lite master handshake bundle around cr_biu_arb.
interface cr_biu_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  ifu_biu_req;
  logic [ADDR_WIDTH-1:0] ifu_biu_addr;
  logic [3:0]            ifu_biu_prot;
  logic                  lsu_biu_req;
  logic [ADDR_WIDTH-1:0] lsu_biu_addr;
  logic                  lsu_biu_write;
  logic [1:0]            lsu_biu_size;
  logic [3:0]            lsu_biu_prot;
  logic [DATA_WIDTH-1:0] lsu_biu_wdata;

  logic                  cpu_req_grnt;
  logic                  cpu_trans_cmplt;
  logic                  cpu_data_vld;
  logic                  cpu_acc_err;
  logic [DATA_WIDTH-1:0] cpu_rdata;

  logic                  cpu_req;
  logic                  cpu_write;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [1:0]            cpu_size;
  logic [3:0]            cpu_prot;
  logic [DATA_WIDTH-1:0] cpu_wr_data;

  logic                  ifu_biu_grnt;
  logic                  ifu_biu_trans_cmplt;
  logic                  ifu_biu_data_vld;
  logic                  ifu_biu_acc_err;
  logic                  lsu_biu_grnt;
  logic                  lsu_biu_trans_cmplt;
  logic                  lsu_biu_data_vld;
  logic                  lsu_biu_acc_err;
  logic [DATA_WIDTH-1:0] biu_rdata;
  logic                  biu_arb_idle;

  // The arbiter itself is the slave side of this bundle.
  modport slave (
    input  ifu_biu_req, ifu_biu_addr, ifu_biu_prot,
    input  lsu_biu_req, lsu_biu_addr, lsu_biu_write, lsu_biu_size, lsu_biu_prot, lsu_biu_wdata,
    input  cpu_req_grnt, cpu_trans_cmplt, cpu_data_vld, cpu_acc_err, cpu_rdata,
    output cpu_req, cpu_write, cpu_addr, cpu_size, cpu_prot, cpu_wr_data,
    output ifu_biu_grnt, ifu_biu_trans_cmplt, ifu_biu_data_vld, ifu_biu_acc_err,
    output lsu_biu_grnt, lsu_biu_trans_cmplt, lsu_biu_data_vld, lsu_biu_acc_err,
    output biu_rdata, biu_arb_idle
  );

  modport master (
    output ifu_biu_req, ifu_biu_addr, ifu_biu_prot,
    output lsu_biu_req, lsu_biu_addr, lsu_biu_write, lsu_biu_size, lsu_biu_prot, lsu_biu_wdata,
    output cpu_req_grnt, cpu_trans_cmplt, cpu_data_vld, cpu_acc_err, cpu_rdata,
    input  cpu_req, cpu_write, cpu_addr, cpu_size, cpu_prot, cpu_wr_data,
    input  ifu_biu_grnt, ifu_biu_trans_cmplt, ifu_biu_data_vld, ifu_biu_acc_err,
    input  lsu_biu_grnt, lsu_biu_trans_cmplt, lsu_biu_data_vld, lsu_biu_acc_err,
    input  biu_rdata, biu_arb_idle
  );
endinterface

// File: rtl/cr_biu_arb_pick.sv
// Combinational address-phase picker. BIU_ARB_RR_EN selects round-robin,
// otherwise LSU has fixed priority over IFU.
module cr_biu_arb_pick
  import cr_biu_arb_pkg::*;
(
  input  logic     ifu_req,
  input  logic     lsu_req,
  input  logic     lock,
  input  biu_sel_e lock_sel,
  input  biu_sel_e last_grnt,
  output biu_sel_e addr_sel
);

`ifdef BIU_ARB_RR_EN
  always_comb begin
    addr_sel = BIU_SEL_IFU;
    if (lock) begin
      addr_sel = lock_sel;
    end else if (ifu_req && lsu_req) begin
      addr_sel = biu_other_sel(last_grnt);
    end else if (lsu_req) begin
      addr_sel = BIU_SEL_LSU;
    end
  end
`else
  // Fixed priority has no history; last_grnt is tied off by the parent.
  logic unused_last_grnt;
  logic unused_ifu_req;
  assign unused_last_grnt = last_grnt;
  assign unused_ifu_req   = ifu_req;

  always_comb begin
    addr_sel = BIU_SEL_IFU;
    if (lock) begin
      addr_sel = lock_sel;
    end else if (lsu_req) begin
      addr_sel = BIU_SEL_LSU;
    end
  end
`endif

endmodule

// File: rtl/cr_biu_arb.sv
// IFU/LSU arbiter in front of the AHB-Lite master: address-phase lock, data-phase
// owner tracking and response routing. BIU_ARB_RR_EN enables round-robin picking.
module cr_biu_arb
  import cr_biu_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic         ahbl_gated_clk,
  input  logic         cpurst,
  cr_biu_arb_if.slave  bus
);

  biu_sel_e addr_sel;
  biu_sel_e last_grnt;
  biu_sel_e lock_sel_q, lock_sel_d;
  biu_sel_e dp_sel_q, dp_sel_d;
  logic     lock_q, lock_d;
  logic     dp_vld_q, dp_vld_d;

  logic                  cpu_req_w;
  logic                  cpu_write_w;
  logic [ADDR_WIDTH-1:0] cpu_addr_w;
  logic [1:0]            cpu_size_w;
  logic [3:0]            cpu_prot_w;
  logic [DATA_WIDTH-1:0] cpu_wr_data_w;
  logic                  grant;
  logic                  rsp_ifu;
  logic                  rsp_lsu;

  cr_biu_arb_pick u_pick (
    .ifu_req   (bus.ifu_biu_req),
    .lsu_req   (bus.lsu_biu_req),
    .lock      (lock_q),
    .lock_sel  (lock_sel_q),
    .last_grnt (last_grnt),
    .addr_sel  (addr_sel)
  );

  always_comb begin
    cpu_req_w   = bus.ifu_biu_req;
    cpu_addr_w  = bus.ifu_biu_addr;
    cpu_write_w = 1'b0;
    cpu_size_w  = BIU_IFU_SIZE;
    cpu_prot_w  = bus.ifu_biu_prot;
    if (addr_sel == BIU_SEL_LSU) begin
      cpu_req_w   = bus.lsu_biu_req;
      cpu_addr_w  = bus.lsu_biu_addr;
      cpu_write_w = bus.lsu_biu_write;
      cpu_size_w  = bus.lsu_biu_size;
      cpu_prot_w  = bus.lsu_biu_prot;
    end
  end

  assign cpu_wr_data_w = bus.lsu_biu_wdata;
  assign grant         = cpu_req_w & bus.cpu_req_grnt;

  // Lock holds the address phase stable through hready-low wait states.
  always_comb begin
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
    if (bus.cpu_req_grnt) begin
      lock_d = 1'b0;
    end else if (cpu_req_w) begin
      lock_d     = 1'b1;
      lock_sel_d = addr_sel;
    end
  end

  // A grant in the completion cycle hands the data phase straight to the new owner.
  always_comb begin
    dp_vld_d = dp_vld_q;
    dp_sel_d = dp_sel_q;
    if (grant) begin
      dp_vld_d = 1'b1;
      dp_sel_d = addr_sel;
    end else if (bus.cpu_trans_cmplt) begin
      dp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge ahbl_gated_clk) begin
    if (cpurst) begin
      lock_q     <= 1'b0;
      lock_sel_q <= BIU_SEL_IFU;
      dp_vld_q   <= 1'b0;
      dp_sel_q   <= BIU_SEL_IFU;
    end else begin
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      dp_vld_q   <= dp_vld_d;
      dp_sel_q   <= dp_sel_d;
    end
  end

`ifdef BIU_ARB_RR_EN
  biu_sel_e last_grnt_q, last_grnt_d;

  always_comb begin
    last_grnt_d = last_grnt_q;
    if (grant) begin
      last_grnt_d = addr_sel;
    end
  end

  always_ff @(posedge ahbl_gated_clk) begin
    if (cpurst) begin
      last_grnt_q <= BIU_SEL_IFU;
    end else begin
      last_grnt_q <= last_grnt_d;
    end
  end

  assign last_grnt = last_grnt_q;
`else
  assign last_grnt = BIU_SEL_IFU;
`endif

  assign rsp_ifu = dp_vld_q & (dp_sel_q == BIU_SEL_IFU);
  assign rsp_lsu = dp_vld_q & (dp_sel_q == BIU_SEL_LSU);

  assign bus.cpu_req     = cpu_req_w;
  assign bus.cpu_write   = cpu_write_w;
  assign bus.cpu_addr    = cpu_addr_w;
  assign bus.cpu_size    = cpu_size_w;
  assign bus.cpu_prot    = cpu_prot_w;
  assign bus.cpu_wr_data = cpu_wr_data_w;

  assign bus.ifu_biu_grnt        = grant & (addr_sel == BIU_SEL_IFU);
  assign bus.lsu_biu_grnt        = grant & (addr_sel == BIU_SEL_LSU);
  assign bus.ifu_biu_trans_cmplt = rsp_ifu & bus.cpu_trans_cmplt;
  assign bus.ifu_biu_data_vld    = rsp_ifu & bus.cpu_data_vld;
  assign bus.ifu_biu_acc_err     = rsp_ifu & bus.cpu_acc_err;
  assign bus.lsu_biu_trans_cmplt = rsp_lsu & bus.cpu_trans_cmplt;
  assign bus.lsu_biu_data_vld    = rsp_lsu & bus.cpu_data_vld;
  assign bus.lsu_biu_acc_err     = rsp_lsu & bus.cpu_acc_err;

  assign bus.biu_rdata    = bus.cpu_rdata;
  assign bus.biu_arb_idle = ~lock_q & ~dp_vld_q;

endmodule

// File: tb/tb_cr_biu_arb.sv
// Directed self-checking bench for cr_biu_arb (fixed priority, or round-robin
// when built with BIU_ARB_RR_EN).
module tb_cr_biu_arb;

`ifdef BIU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   exp_lsu;
  bit   prev_lsu;

  always #5 clk = ~clk;

  cr_biu_arb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

  cr_biu_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ahbl_gated_clk (clk),
    .cpurst         (rst),
    .bus            (bus_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clr_hs();
    bus_if.ifu_biu_req     = 1'b0;
    bus_if.lsu_biu_req     = 1'b0;
    bus_if.cpu_req_grnt    = 1'b0;
    bus_if.cpu_trans_cmplt = 1'b0;
    bus_if.cpu_data_vld    = 1'b0;
    bus_if.cpu_acc_err     = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr_hs();
    bus_if.ifu_biu_addr  = 32'h0000_1000;
    bus_if.ifu_biu_prot  = 4'hA;
    bus_if.lsu_biu_addr  = 32'h2000_0004;
    bus_if.lsu_biu_write = 1'b1;
    bus_if.lsu_biu_size  = 2'b10;
    bus_if.lsu_biu_prot  = 4'h3;
    bus_if.lsu_biu_wdata = 32'hDEAD_BEEF;
    bus_if.cpu_rdata     = 32'h0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_idle", bus_if.biu_arb_idle, 1);
    chk("rst_cpu_req", bus_if.cpu_req, 0);
    chk("rst_grnts", {bus_if.ifu_biu_grnt, bus_if.lsu_biu_grnt}, 0);
    chk("rst_addr", bus_if.cpu_addr, 32'h0000_1000);
    chk("rst_size", bus_if.cpu_size, 2'b10);
    chk("rst_write", bus_if.cpu_write, 0);
    chk("rst_prot", bus_if.cpu_prot, 4'hA);

    // IFU alone: grant, then data
    @(negedge clk); rst = 1'b0;
    bus_if.ifu_biu_req = 1'b1; bus_if.cpu_req_grnt = 1'b1; #1;
    chk("t1_cpu_req", bus_if.cpu_req, 1);
    chk("t1_ifu_grnt", bus_if.ifu_biu_grnt, 1);
    chk("t1_lsu_grnt", bus_if.lsu_biu_grnt, 0);
    @(negedge clk); clr_hs();
    bus_if.cpu_trans_cmplt = 1'b1; bus_if.cpu_data_vld = 1'b1; bus_if.cpu_rdata = 32'h1234_5678; #1;
    chk("t1_ifu_dvld", bus_if.ifu_biu_data_vld, 1);
    chk("t1_ifu_cmplt", bus_if.ifu_biu_trans_cmplt, 1);
    chk("t1_rdata", bus_if.biu_rdata, 32'h1234_5678);
    chk("t1_lsu_outs", {bus_if.lsu_biu_grnt, bus_if.lsu_biu_trans_cmplt, bus_if.lsu_biu_data_vld, bus_if.lsu_biu_acc_err}, 0);
    @(negedge clk); clr_hs(); #1;
    chk("t1_idle", bus_if.biu_arb_idle, 1);

    // Both request: LSU write first, IFU granted back-to-back
    @(negedge clk);
    bus_if.ifu_biu_req = 1'b1; bus_if.lsu_biu_req = 1'b1; bus_if.cpu_req_grnt = 1'b1; #1;
    chk("t2_lsu_grnt", bus_if.lsu_biu_grnt, 1);
    chk("t2_ifu_grnt", bus_if.ifu_biu_grnt, 0);
    chk("t2_addr", bus_if.cpu_addr, 32'h2000_0004);
    chk("t2_write", bus_if.cpu_write, 1);
    chk("t2_wdata", bus_if.cpu_wr_data, 32'hDEAD_BEEF);
    @(negedge clk);
    bus_if.lsu_biu_req = 1'b0; bus_if.cpu_trans_cmplt = 1'b1; #1;
    chk("t2_lsu_cmplt", bus_if.lsu_biu_trans_cmplt, 1);
    chk("t2_ifu_cmplt0", bus_if.ifu_biu_trans_cmplt, 0);
    chk("t2_ifu_grnt_b2b", bus_if.ifu_biu_grnt, 1);
    chk("t2_ifu_write", bus_if.cpu_write, 0);
    @(negedge clk); clr_hs();
    bus_if.cpu_trans_cmplt = 1'b1; bus_if.cpu_data_vld = 1'b1; bus_if.cpu_rdata = 32'hCAFE_F00D; #1;
    chk("t2_ifu_dvld", bus_if.ifu_biu_data_vld, 1);
    chk("t2_lsu_cmplt_after", bus_if.lsu_biu_trans_cmplt, 0);

    // LSU locked through 3 wait cycles while IFU raises its request
    @(negedge clk); clr_hs();
    bus_if.lsu_biu_req = 1'b1; bus_if.lsu_biu_addr = 32'h3000_0008;
    bus_if.lsu_biu_write = 1'b0; bus_if.lsu_biu_size = 2'b01; #1;
    chk("t3_cpu_req", bus_if.cpu_req, 1);
    chk("t3_addr0", bus_if.cpu_addr, 32'h3000_0008);
    chk("t3_size", bus_if.cpu_size, 2'b01);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); bus_if.ifu_biu_req = 1'b1; #1;
      chk("t3_addr_wait", bus_if.cpu_addr, 32'h3000_0008);
      chk("t3_ifu_no_grnt", bus_if.ifu_biu_grnt, 0);
      chk("t3_not_idle", bus_if.biu_arb_idle, 0);
    end
    @(negedge clk); bus_if.cpu_req_grnt = 1'b1; #1;
    chk("t3_lsu_grnt", bus_if.lsu_biu_grnt, 1);
    chk("t3_ifu_grnt", bus_if.ifu_biu_grnt, 0);
    // IFU now locks while the LSU comes back with a write
    @(negedge clk);
    bus_if.lsu_biu_req = 1'b0; bus_if.cpu_req_grnt = 1'b0;
    bus_if.cpu_trans_cmplt = 1'b1; bus_if.cpu_data_vld = 1'b1; bus_if.cpu_rdata = 32'h0BAD_F00D; #1;
    chk("t3_lsu_dvld", bus_if.lsu_biu_data_vld, 1);
    chk("t3_ifu_dvld", bus_if.ifu_biu_data_vld, 0);
    chk("t3_ifu_wait_grnt", bus_if.ifu_biu_grnt, 0);
    @(negedge clk);
    bus_if.cpu_trans_cmplt = 1'b0; bus_if.cpu_data_vld = 1'b0;
    bus_if.lsu_biu_req = 1'b1; bus_if.lsu_biu_addr = 32'h3000_0010; bus_if.lsu_biu_write = 1'b1; #1;
    chk("t3_ifu_locked_addr", bus_if.cpu_addr, 32'h0000_1000);
    chk("t3_ifu_locked_wr", bus_if.cpu_write, 0);
    @(negedge clk); bus_if.cpu_req_grnt = 1'b1; #1;
    chk("t3_ifu_grnt", bus_if.ifu_biu_grnt, 1);
    chk("t3_lsu_no_grnt", bus_if.lsu_biu_grnt, 0);
    @(negedge clk); clr_hs(); bus_if.cpu_trans_cmplt = 1'b1; bus_if.cpu_data_vld = 1'b1; #1;
    chk("t3_ifu_dvld2", bus_if.ifu_biu_data_vld, 1);

    // Error response on an LSU read
    @(negedge clk); clr_hs();
    bus_if.lsu_biu_req = 1'b1; bus_if.lsu_biu_addr = 32'h4000_0000;
    bus_if.lsu_biu_write = 1'b0; bus_if.cpu_req_grnt = 1'b1; #1;
    chk("t4_lsu_grnt", bus_if.lsu_biu_grnt, 1);
    @(negedge clk); clr_hs(); #1;
    chk("t4_err1_err", bus_if.lsu_biu_acc_err, 0);
    chk("t4_err1_busy", bus_if.biu_arb_idle, 0);
    @(negedge clk); bus_if.cpu_trans_cmplt = 1'b1; bus_if.cpu_acc_err = 1'b1; #1;
    chk("t4_err2_err", bus_if.lsu_biu_acc_err, 1);
    chk("t4_err2_cmplt", bus_if.lsu_biu_trans_cmplt, 1);
    chk("t4_err2_dvld", bus_if.lsu_biu_data_vld, 0);
    chk("t4_ifu_err", bus_if.ifu_biu_acc_err, 0);
    @(negedge clk); clr_hs(); #1;
    chk("t4_idle", bus_if.biu_arb_idle, 1);

    // Reset during an outstanding IFU data phase
    @(negedge clk); bus_if.ifu_biu_req = 1'b1; bus_if.cpu_req_grnt = 1'b1; #1;
    chk("t6_ifu_grnt", bus_if.ifu_biu_grnt, 1);
    @(negedge clk); clr_hs(); rst = 1'b1; #1;
    chk("t6_busy", bus_if.biu_arb_idle, 0);
    @(negedge clk); rst = 1'b0; bus_if.cpu_trans_cmplt = 1'b1; bus_if.cpu_data_vld = 1'b1; #1;
    chk("t6_cmplt_drop", bus_if.ifu_biu_trans_cmplt, 0);
    chk("t6_dvld_drop", bus_if.ifu_biu_data_vld, 0);
    chk("t6_idle", bus_if.biu_arb_idle, 1);

    // Both requesters continuously active, 6 back-to-back grants
    @(negedge clk); clr_hs();
    prev_lsu = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus_if.ifu_biu_req = 1'b1; bus_if.lsu_biu_req = 1'b1;
      bus_if.cpu_req_grnt = 1'b1; bus_if.cpu_trans_cmplt = (i != 0); #1;
      exp_lsu = RR ? (i % 2 == 0) : 1'b1;
      chk("arb_lsu_grnt", bus_if.lsu_biu_grnt, exp_lsu);
      chk("arb_ifu_grnt", bus_if.ifu_biu_grnt, !exp_lsu);
      if (i != 0) begin
        chk("arb_lsu_cmplt", bus_if.lsu_biu_trans_cmplt, prev_lsu);
        chk("arb_ifu_cmplt", bus_if.ifu_biu_trans_cmplt, !prev_lsu);
      end
      prev_lsu = exp_lsu;
    end
    @(negedge clk); clr_hs(); bus_if.cpu_trans_cmplt = 1'b1; #1;
    chk("arb_last_lsu_cmplt", bus_if.lsu_biu_trans_cmplt, prev_lsu);
    chk("arb_last_ifu_cmplt", bus_if.ifu_biu_trans_cmplt, !prev_lsu);
    @(negedge clk); clr_hs(); #1;
    chk("arb_idle", bus_if.biu_arb_idle, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
